// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter with inhibit/RTS, device-clocked shift-out and ACK check
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 2400,
   parameter int START_TIMEOUT  = 360000,
   parameter int XFER_TIMEOUT   = 48000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       KBD_CLK,
   input  logic       KBD_DATA,
   output logic       kbdClkDriveLow,
   output logic       kbdDataDriveLow,
   input  logic [7:0] txData,
   input  logic       txValid,
   output logic       txReady,
   output logic       txDone,
   output logic       txError,
   output logic       rxInhibit
);
   typedef enum logic [2:0] {IDLE, INHIBIT, REQ, WAIT_START, SHIFT, WAIT_IDLE, FAIL} stateT;
   localparam logic [18:0] INH_T   = 19'(INHIBIT_CYCLES);
   localparam logic [18:0] START_T = 19'(START_TIMEOUT);
   localparam logic [18:0] XFER_T  = 19'(XFER_TIMEOUT);
   stateT       state;
   logic [2:0]  clkSync;
   logic [1:0]  dataSync;
   logic [18:0] timer, timerInc;
   logic [3:0]  bitCnt;
   logic [7:0]  shByte;
   logic        par, clkS, datS, fall, failNow;
   assign clkS     = clkSync[1];
   assign datS     = dataSync[1];
   assign fall     = clkSync[2] & ~clkSync[1];
   assign timerInc = &timer ? timer : timer + 19'd1;
   // every abort path funnels through here so lines release and txError pulse together
   always_comb begin
      failNow = (state == WAIT_START && !fall && timer >= START_T)
             || ((state == SHIFT || state == WAIT_IDLE) && timer >= XFER_T)
             || (state == SHIFT && fall && bitCnt == 4'd10 && datS);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         clkSync         <= '1;
         dataSync        <= '1;
         state           <= IDLE;
         kbdClkDriveLow  <= 1'b0;
         kbdDataDriveLow <= 1'b0;
         txReady         <= 1'b1;
         rxInhibit       <= 1'b0;
         txDone          <= 1'b0;
         txError         <= 1'b0;
         timer           <= '0;
         bitCnt          <= '0;
         shByte          <= '0;
         par             <= 1'b0;
      end else begin
         clkSync  <= {clkSync[1:0], KBD_CLK};
         dataSync <= {dataSync[0], KBD_DATA};
         txDone   <= 1'b0;
         txError  <= 1'b0;
         if (failNow) begin
            state           <= FAIL;
            kbdClkDriveLow  <= 1'b0;
            kbdDataDriveLow <= 1'b0;
            txError         <= 1'b1;
         end else begin
            case (state)
               IDLE: if (txValid && txReady) begin
                  shByte         <= txData;
                  par            <= ~^txData;
                  timer          <= '0;
                  kbdClkDriveLow <= 1'b1;
                  txReady        <= 1'b0;
                  rxInhibit      <= 1'b1;
                  state          <= INHIBIT;
               end
               INHIBIT: begin
                  timer <= timerInc;
                  if (timer == INH_T - 19'd2) kbdDataDriveLow <= 1'b1;
                  if (timer == INH_T - 19'd1) begin
                     kbdDataDriveLow <= 1'b1;
                     kbdClkDriveLow  <= 1'b0;
                     state           <= REQ;
                  end
               end
               REQ: begin
                  timer  <= '0;
                  bitCnt <= '0;
                  state  <= WAIT_START;
               end
               WAIT_START: if (fall) begin
                  state           <= SHIFT;
                  bitCnt          <= 4'd1;
                  kbdDataDriveLow <= ~shByte[0];
                  timer           <= '0;
               end else timer <= timerInc;
               SHIFT: begin
                  timer <= timerInc;
                  if (fall) begin
                     bitCnt <= bitCnt + 4'd1;
                     if (bitCnt <= 4'd7) kbdDataDriveLow <= ~shByte[bitCnt[2:0]];
                     else if (bitCnt == 4'd8) kbdDataDriveLow <= ~par;
                     else if (bitCnt == 4'd9) kbdDataDriveLow <= 1'b0;
                     else state <= WAIT_IDLE;
                  end
               end
               WAIT_IDLE: begin
                  timer <= timerInc;
                  if (clkS && datS) begin
                     txDone    <= 1'b1;
                     txReady   <= 1'b1;
                     rxInhibit <= 1'b0;
                     state     <= IDLE;
                  end
               end
               FAIL: begin
                  txReady   <= 1'b1;
                  rxInhibit <= 1'b0;
                  state     <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule
